// File: rtl/guess_compare_fsm.sv
// Number-guessing game controller: latches target/guess, drives the comparator, registers hints/win/lose.
// Optional attempt limit enabled by defining GUESS_LIMIT_EN.
module guess_compare_fsm #(
    parameter int unsigned MAX_TRIES = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] target,
    input  logic [3:0] guess,
    input  logic       load,
    input  logic       submit,
    input  logic       cmp_e,
    input  logic       cmp_x,
    input  logic       cmp_y,
    output logic [3:0] cmp_a,
    output logic [3:0] cmp_b,
    output logic       too_low,
    output logic       too_high,
    output logic       win,
    output logic       lose,
    output logic [3:0] tries,
    output logic       playing
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_CMP  = 3'd2;
    localparam logic [2:0] S_WIN  = 3'd3;
`ifdef GUESS_LIMIT_EN
    localparam logic [2:0] S_LOSE = 3'd4;
`endif

    if (MAX_TRIES < 1 || MAX_TRIES > 15) begin : g_bad_max_tries
        $error("guess_compare_fsm: MAX_TRIES must be in 1..15");
    end

    logic [2:0] state;
    logic [3:0] target_q;
    logic [3:0] guess_q;
    logic       submit_d;
    logic       sub_rise;

    assign sub_rise = submit & ~submit_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            target_q <= '0;
            guess_q  <= '0;
            tries    <= '0;
            too_low  <= 1'b0;
            too_high <= 1'b0;
            submit_d <= 1'b0;
        end else begin
            submit_d <= submit;
            if (load) begin
                target_q <= target;
                tries    <= '0;
                too_low  <= 1'b0;
                too_high <= 1'b0;
                state    <= S_PLAY;
            end else begin
                case (state)
                    S_PLAY: begin
                        if (sub_rise) begin
                            guess_q <= guess;
                            if (tries != 4'd15) begin
                                tries <= tries + 4'd1;
                            end
                            state <= S_CMP;
                        end
                    end
                    // Comparator flags are combinational on cmp_a/cmp_b, so they are valid here.
                    S_CMP: begin
                        too_low  <= cmp_y;
                        too_high <= cmp_x;
                        if (cmp_e) begin
                            state <= S_WIN;
`ifdef GUESS_LIMIT_EN
                        end else if (tries == 4'(MAX_TRIES)) begin
                            state <= S_LOSE;
`endif
                        end else begin
                            state <= S_PLAY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmp_a   = guess_q;
    assign cmp_b   = target_q;
    assign win     = (state == S_WIN);
    assign playing = (state == S_PLAY) || (state == S_CMP);
`ifdef GUESS_LIMIT_EN
    assign lose    = (state == S_LOSE);
`else
    assign lose    = 1'b0;
`endif

endmodule

// File: tb/tb_guess_compare_fsm.sv
// Bench for guess_compare_fsm: signed comparator stand-in, game-rule model checked every cycle, directed literals.
module tb_guess_compare_fsm;

    localparam int MAXT = 7;
`ifdef GUESS_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] target, guess;
    logic       load, submit;
    logic       cmp_e, cmp_x, cmp_y;
    logic [3:0] cmp_a, cmp_b, tries;
    logic       too_low, too_high, win, lose, playing;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    guess_compare_fsm #(.MAX_TRIES(MAXT)) dut (
        .clk(clk), .reset(reset), .target(target), .guess(guess),
        .load(load), .submit(submit),
        .cmp_e(cmp_e), .cmp_x(cmp_x), .cmp_y(cmp_y),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .too_low(too_low), .too_high(too_high), .win(win), .lose(lose),
        .tries(tries), .playing(playing)
    );

    // Upstream signed comparator
    assign cmp_e = (cmp_a == cmp_b);
    assign cmp_x = ($signed(cmp_a) > $signed(cmp_b));
    assign cmp_y = ($signed(cmp_a) < $signed(cmp_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Game-rule model: what a player should observe, tracked per clock
    logic [3:0] m_target = '0, m_guess = '0;
    int  m_tries = 0;
    bit  m_low = 0, m_high = 0, m_won = 0, m_lost = 0;
    bit  m_active = 0, m_pending = 0, m_sub_prev = 0;

    always @(posedge clk or posedge reset) begin
        int  gi, ti;
        bit  rise;
        if (reset) begin
            m_target = '0; m_guess = '0; m_tries = 0;
            m_low = 0; m_high = 0; m_won = 0; m_lost = 0;
            m_active = 0; m_pending = 0; m_sub_prev = 0;
        end else begin
            rise = submit && !m_sub_prev;
            m_sub_prev = submit;
            if (load) begin
                m_target = target; m_tries = 0; m_low = 0; m_high = 0;
                m_pending = 0; m_active = 1; m_won = 0; m_lost = 0;
            end else if (m_pending) begin
                gi = int'($signed(m_guess));
                ti = int'($signed(m_target));
                m_low  = (gi < ti);
                m_high = (gi > ti);
                m_pending = 0;
                if (gi == ti) begin
                    m_won = 1; m_active = 0;
                end else if (LIM && m_tries == MAXT) begin
                    m_lost = 1; m_active = 0;
                end
            end else if (m_active && rise) begin
                m_guess = guess;
                m_tries = (m_tries < 15) ? m_tries + 1 : 15;
                m_pending = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] got, expv;
        if (check_en) begin
            got  = {cmp_a, cmp_b, too_low, too_high, win, lose, tries, playing};
            expv = {m_guess, m_target, m_low, m_high, m_won, m_lost, 4'(m_tries), m_active};
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL cycle_model t=%0t actual=%h expected=%h", $time, got, expv);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_load(input logic [3:0] t);
        target = t; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Rising submit edge, then one cycle low: verdict valid on return
    task automatic submit_guess(input logic [3:0] g);
        guess = g; submit = 1'b1;
        tick();
        submit = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, int'({cmp_a, cmp_b, too_low, too_high, win, lose, tries, playing}), 0);
    endtask

    initial begin
        reset = 1'b1;
        load = 1'b0; submit = 1'b0;
        target = 4'($urandom); guess = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
            submit = ~submit; target = 4'($urandom); guess = 4'($urandom);
            load = 1'($urandom);
            tick();
        end
        load = 1'b0; submit = 1'b0;
        chk_all_zero("reset_outputs");
        check_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        submit_guess(4'd3);
        chk("idle_submit_playing", int'(playing), 0);
        chk("idle_submit_tries", int'(tries), 0);

        // Hint sequence
        do_load(4'd3);
        chk("load_playing", int'(playing), 1);
        guess = 4'hE; submit = 1'b1;
        tick();
        chk("cmp_state_tries", int'(tries), 1);
        chk("cmp_state_cmp_a", int'(cmp_a), 14);
        submit = 1'b0;
        tick();
        chk("neg2_too_low", int'({too_low, too_high}), 2);
        submit_guess(4'd7);
        chk("g7_too_high", int'({too_low, too_high}), 1);
        chk("g7_tries", int'(tries), 2);

        // Signed boundaries
        do_load(4'h8);
        submit_guess(4'd7);
        chk("t_m8_g7_high", int'({too_low, too_high}), 1);
        do_load(4'd7);
        submit_guess(4'h8);
        chk("t7_g_m8_low", int'({too_low, too_high}), 2);

        // Win and hold
        do_load(4'd5);
        submit_guess(4'd5);
        chk("win_flags", int'({win, playing, lose}), 4);
        chk("win_tries", int'(tries), 1);
        submit_guess(4'd1);
        submit_guess(4'd5);
        chk("win_hold", int'({win, tries}), 17);
        do_load(4'd5);
        chk("win_cleared", int'({win, tries}), 0);

        // Attempt limit / saturation
        do_load(4'd0);
        for (int i = 0; i < 7; i++) submit_guess(4'd1);
        chk("limit7_lose", int'(lose), LIM ? 1 : 0);
        chk("limit7_tries", int'(tries), 7);
        chk("limit7_playing", int'(playing), LIM ? 0 : 1);
        for (int i = 0; i < 13; i++) submit_guess(4'd1);
        chk("limit20_tries", int'(tries), LIM ? 7 : 15);
        chk("limit20_lose", int'(lose), LIM ? 1 : 0);

        // Submit held high: one attempt only
        do_load(4'd2);
        guess = 4'd1; submit = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("held_submit_tries", int'(tries), 1);
        submit = 1'b0;
        tick();

        // Load coincident with a submit rising edge
        target = 4'd4; load = 1'b1; submit = 1'b1;
        tick();
        load = 1'b0;
        chk("load_collide", int'({tries, playing}), 1);
        tick();
        chk("load_collide_after", int'({tries, playing}), 1);
        submit = 1'b0;
        tick();

        // Reset while in CMP
        guess = 4'd1; submit = 1'b1;
        tick();
        chk("pre_reset_cmp", int'({tries, playing}), 3);
        #1 reset = 1'b1;
        #1;
        chk_all_zero("reset_in_cmp");
        submit = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk_all_zero("after_reset_cmp");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/guess_compare_fsm.md
# guess_compare_fsm

Sequential control stage that sits directly downstream of the 4-bit signed comparator and consumes its equal/greater/less flags. It latches a secret target and user guesses, drives both comparator operands, and registers the comparator verdict into hint, win and lose outputs. It also counts attempts and, optionally, enforces an attempt limit. It forms the game/controller layer of the number-guessing lab datapath.

## Interface
- MAX_TRIES, 7, attempts allowed before LOSE when the limit feature is compiled in (legal 1..15)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- target  in  4  two's-complement target value, sampled while load=1
- guess  in  4  two's-complement guess value, sampled on a submit rising edge
- load  in  1  level; (re)starts a game with the current target
- submit  in  1  level (debounced button); only its rising edge acts
- cmp_e  in  1  comparator A==B
- cmp_x  in  1  comparator A>B (signed)
- cmp_y  in  1  comparator A<B (signed, overflow-corrected)
- cmp_a  out  4  comparator operand A = registered guess
- cmp_b  out  4  comparator operand B = registered target
- too_low  out  1  last guess < target
- too_high  out  1  last guess > target
- win  out  1  guess matched target
- lose  out  1  attempt limit exhausted
- tries  out  4  attempts this game, saturating at 15
- playing  out  1  high in PLAY or CMP

## Operation
- Registers: target_q, guess_q, tries, too_low, too_high, submit_d, and a state in {IDLE, PLAY, CMP, WIN, LOSE}.
- Edge detect: sub_rise = submit & ~submit_d. submit_d updates every cycle in every state.
- load=1 in any state (highest priority after reset): target_q<=target, tries<=0, too_low/too_high<=0, state<=PLAY. A coincident sub_rise is ignored.
- IDLE: waits for load. sub_rise is ignored.
- PLAY: on sub_rise: guess_q<=guess, tries<=tries+1 (hold at 15), state<=CMP.
- CMP, lasting exactly one cycle: too_low<=cmp_y, too_high<=cmp_x.
  - If cmp_e: state<=WIN.
  - Else, with the limit compiled in and tries==MAX_TRIES: state<=LOSE.
  - Otherwise: state<=PLAY.
  - A sub_rise arriving during CMP is dropped.
- WIN/LOSE: hold all outputs. Only load or reset leaves these states. sub_rise is ignored.
- win = (state==WIN), lose = (state==LOSE), playing = (state==PLAY or CMP). All are decoded from registered state.
- cmp_a=guess_q and cmp_b=target_q are driven continuously. The block treats cmp_e/x/y as combinational functions of cmp_a/cmp_b that are valid in the same cycle.
- Arithmetic is signed 4-bit two's complement (−8..7). The comparator handles overflow; this block does no arithmetic beyond the tries increment.

## Timing
- Reset values: state=IDLE, target_q=0, guess_q=0, tries=0, submit_d=0.
  - Therefore all outputs are 0: cmp_a=0, cmp_b=0, too_low=0, too_high=0, win=0, lose=0, tries=0, playing=0.
- Reset asserted mid-game, including in CMP: everything returns to the reset values at once, with no pending verdict.
- Guess latency: submit is low at edge k−1 and high at edge k.
  - After edge k: state=CMP, tries is incremented, cmp_a=guess.
  - After edge k+1: too_low/too_high/win/lose are valid.
  - Total: 2 clocks.
- submit held high produces exactly one attempt. A new attempt requires submit to go low for at least one sampled edge, then high again.
- Load latency: one edge. playing=1 and the hints are cleared after the edge where load=1.
- tries saturates at 15 and never wraps.

## Configuration
- GUESS_LIMIT_EN defined: LOSE is reachable. A non-matching CMP with tries==MAX_TRIES enters LOSE.
- GUESS_LIMIT_EN undefined:
  - The LOSE transition is removed and lose is tied to 0.
  - Play is unlimited.
  - tries still counts and saturates at 15.

## Test plan
- Reset test: assert reset with random inputs → all outputs 0, state IDLE. Then pulse submit → no change.
- Hint sequence: load target=3, then submit guess=−2 → after 2 clocks too_low=1, too_high=0, tries=1. Then submit guess=7 → too_high=1, too_low=0, tries=2.
- Signed boundary: load target=−8, submit guess=7 → too_high=1. Then load target=7, submit guess=−8 → too_low=1.
- Win: target=5, submit guess=5 → win=1, playing=0, tries=1. Further submit edges → no change. Then load → win=0, tries=0.
- Limit (macro on, MAX_TRIES=7): seven wrong guesses → lose=1 after the 7th. With the macro off, the same stimulus gives lose=0 and tries=7, and 20 wrong guesses give tries=15.
- Collisions:
  - Hold submit high for 10 cycles → tries increments by 1 only.
  - load coincident with sub_rise → tries=0, state PLAY.
  - reset asserted during CMP → all outputs 0.
